// File: rtl/axi_ch_read_pkg.sv
// axi_ch_read_pkg: shared constants and the Galois LFSR step function
// used by the read-channel backpressure block and its reference model.
package axi_ch_read_pkg;

   localparam int          LFSR_W_DEF = 16;
   localparam logic [31:0] SEED_DEF   = 32'h0000_ACE1;
   localparam logic [31:0] TAPS_DEF   = 32'h0000_B400;

   // One right-shifting Galois step; upper unused bits must be zero.
   function automatic logic [31:0] lfsr_step(
      input logic [31:0] state,
      input logic [31:0] taps
   );
      return (state >> 1) ^ (state[0] ? taps : 32'h0);
   endfunction

endpackage

// File: rtl/axi_lfsr.sv
// axi_lfsr: width-parameterised Galois LFSR, sync reset, enable.
// Ports: clk, rst (sync, high), en (advance), nxt_lsb (bit 0 of next state).
module axi_lfsr
   import axi_ch_read_pkg::*;
#(
   parameter int           W    = LFSR_W_DEF,
   parameter logic [W-1:0] SEED = W'(SEED_DEF),
   parameter logic [W-1:0] TAPS = W'(TAPS_DEF)
) (
   input  logic clk,
   input  logic rst,
   input  logic en,
   output logic nxt_lsb
);

   // An all-zero seed would lock the register at zero forever.
   localparam logic [W-1:0] SEED_SAFE = (SEED == '0) ? W'(1) : SEED;

   logic [W-1:0] state_q;
   logic [W-1:0] state_d;
   logic [W-1:0] state_nxt;

   always_comb begin
      state_nxt = W'(lfsr_step(32'(state_q), 32'(TAPS)));
      state_d   = state_q;
      if (en) begin
         state_d = state_nxt;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= SEED_SAFE;
      end else begin
         state_q <= state_d;
      end
   end

   assign nxt_lsb = state_nxt[0];

endmodule

// File: rtl/axi_ch_read.sv
// axi_ch_read: slave side of a read-channel handshake with LFSR backpressure.
// Ports: clk, anreset (sync, high), valid (in), ready (registered), cs.
module axi_ch_read
   import axi_ch_read_pkg::*;
#(
   parameter int                RANDOM    = 1,
   parameter int                LFSR_W    = LFSR_W_DEF,
   parameter logic [LFSR_W-1:0] SEED      = LFSR_W'(SEED_DEF),
   parameter logic [LFSR_W-1:0] TAPS      = LFSR_W'(TAPS_DEF),
   parameter int                MAX_STALL = 4
) (
   input  logic clk,
   input  logic anreset,
   input  logic valid,
   output logic ready,
   output logic cs
);

   localparam int CNT_W = (MAX_STALL < 2) ? 1 : $clog2(MAX_STALL + 1);
   localparam logic [CNT_W-1:0] CNT_MAX  = CNT_W'(MAX_STALL);
   localparam logic [CNT_W-1:0] CNT_LAST =
      CNT_W'((MAX_STALL == 0) ? 0 : MAX_STALL - 1);
   localparam bit STALL_EN = (MAX_STALL != 0);

   logic             lfsr_bit;
   logic             ready_q;
   logic             ready_d;
   logic [CNT_W-1:0] stall_cnt_q;
   logic [CNT_W-1:0] stall_cnt_d;
   logic             stall;
   logic             force_rdy;

   axi_lfsr #(
      .W    (LFSR_W),
      .SEED (SEED),
      .TAPS (TAPS)
   ) u_lfsr (
      .clk     (clk),
      .rst     (anreset),
      .en      (1'b1),
      .nxt_lsb (lfsr_bit)
   );

   always_comb begin
      stall       = valid && !ready_q;
      // Last allowed stall cycle: ready is guaranteed on the next edge.
      force_rdy   = STALL_EN && stall && (stall_cnt_q == CNT_LAST);
      stall_cnt_d = '0;
      if (stall) begin
         if (stall_cnt_q != CNT_MAX) begin
            stall_cnt_d = stall_cnt_q + CNT_W'(1);
         end else begin
            stall_cnt_d = stall_cnt_q;
         end
      end
      if (RANDOM != 0) begin
         ready_d = lfsr_bit | force_rdy;
      end else begin
         ready_d = 1'b1;
      end
   end

   always_ff @(posedge clk) begin
      if (anreset) begin
         ready_q     <= 1'b0;
         stall_cnt_q <= '0;
      end else begin
         ready_q     <= ready_d;
         stall_cnt_q <= stall_cnt_d;
      end
   end

   assign ready = ready_q;
   assign cs    = valid && ready_q;

endmodule

// File: tb/tb_axi_ch_read.sv
// tb_axi_ch_read: scoreboard bench for axi_ch_read, three configurations
// (non-random, random MAX_STALL=4, random MAX_STALL=2).
module tb_axi_ch_read;
   import axi_ch_read_pkg::*;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic rst0 = 1'b1, rst1 = 1'b1, rst2 = 1'b1;
   logic v0 = 1'b0, v1 = 1'b0, v2 = 1'b0;
   logic r0, c0, r1, c1, r2, c2;

   axi_ch_read #(.RANDOM(0)) u0 (
      .clk(clk), .anreset(rst0), .valid(v0), .ready(r0), .cs(c0)
   );
   axi_ch_read #(.RANDOM(1)) u1 (
      .clk(clk), .anreset(rst1), .valid(v1), .ready(r1), .cs(c1)
   );
   axi_ch_read #(.RANDOM(1), .MAX_STALL(2)) u2 (
      .clk(clk), .anreset(rst2), .valid(v2), .ready(r2), .cs(c2)
   );

   typedef struct {
      string       n;
      logic        r;
      logic        c;
      bit          ck_l;
      logic [15:0] l;
   } exp_t;

   localparam logic [15:0] LTBL [5] =
      '{16'hE270, 16'h7138, 16'h389C, 16'h1C4E, 16'h0E27};
   localparam logic RTBL [5] = '{1'b0, 1'b0, 1'b0, 1'b0, 1'b1};

   exp_t q0[$], q1[$], q2[$];
   int n_chk = 0, n_fail = 0;
   int run2 = 0, max_run2 = 0, cs_cnt2 = 0, rdy_cnt2 = 0;

   task automatic chk(string n, logic [31:0] act, logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", n, act, exp);
      end
   endtask

   function automatic exp_t mk(string n, logic r, logic c,
                               bit ck_l = 1'b0, logic [15:0] l = 16'h0);
      exp_t e;
      e.n = n; e.r = r; e.c = c; e.ck_l = ck_l; e.l = l;
      return e;
   endfunction

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   // Monitor: pops one expectation per DUT per cycle and compares.
   always @(negedge clk) begin
      exp_t e;
      if (q0.size() != 0) begin
         e = q0.pop_front();
         chk({e.n, "/ready"}, 32'(r0), 32'(e.r));
         chk({e.n, "/cs"}, 32'(c0), 32'(e.c));
      end
      if (q1.size() != 0) begin
         e = q1.pop_front();
         chk({e.n, "/ready"}, 32'(r1), 32'(e.r));
         chk({e.n, "/cs"}, 32'(c1), 32'(e.c));
         if (e.ck_l) begin
            chk({e.n, "/lfsr"}, 32'(u1.u_lfsr.state_q), 32'(e.l));
            chk({e.n, "/lfsr_nz"}, 32'(u1.u_lfsr.state_q != '0), 32'd1);
         end
      end
      if (q2.size() != 0) begin
         e = q2.pop_front();
         chk({e.n, "/ready"}, 32'(r2), 32'(e.r));
         chk({e.n, "/cs"}, 32'(c2), 32'(e.c));
         if (v2 && !r2) run2++;
         else run2 = 0;
         if (run2 > max_run2) max_run2 = run2;
         if (c2) cs_cnt2++;
         if (r2) rdy_cnt2++;
      end
   end

   initial begin
      logic [15:0] m;
      logic [15:0] m2;
      logic [15:0] nx;
      logic        rq2;
      logic        f2;
      int          cnt2;
      int          ncnt;

      // Non-random: reset, single pulse, 3-cycle hold, split pulses.
      tick();
      q0.push_back(mk("a_rst", 1'b0, 1'b0));
      tick(); rst0 = 1'b0;
      q0.push_back(mk("a_rel", 1'b0, 1'b0));
      tick(); v0 = 1'b1;
      q0.push_back(mk("a_pulse", 1'b1, 1'b1));
      tick(); v0 = 1'b0;
      q0.push_back(mk("a_idle", 1'b1, 1'b0));
      for (int i = 0; i < 3; i++) begin
         tick(); v0 = 1'b1;
         q0.push_back(mk("a_hold", 1'b1, 1'b1));
      end
      tick(); v0 = 1'b0;
      q0.push_back(mk("a_after", 1'b1, 1'b0));
      tick();
      q0.push_back(mk("a_after", 1'b1, 1'b0));
      tick(); v0 = 1'b1;
      q0.push_back(mk("a_p1", 1'b1, 1'b1));
      tick(); v0 = 1'b0;
      q0.push_back(mk("a_gap", 1'b1, 1'b0));
      tick(); v0 = 1'b1;
      q0.push_back(mk("a_p2", 1'b1, 1'b1));
      tick(); v0 = 1'b0;
      q0.push_back(mk("a_end", 1'b1, 1'b0));

      // Random, valid low: hand table then package model.
      tick(); rst1 = 1'b0;
      m = 16'hACE1;
      q1.push_back(mk("b_rst", 1'b0, 1'b0, 1'b1, m));
      for (int i = 0; i < 1000; i++) begin
         tick();
         m = 16'(lfsr_step(32'(m), TAPS_DEF));
         if (i < 5)
            q1.push_back(mk("b_tbl", RTBL[i], 1'b0, 1'b1, LTBL[i]));
         else
            q1.push_back(mk("b_model", m[0], 1'b0, 1'b1, m));
      end

      // Burst, then reset while valid is high.
      for (int i = 0; i < 6; i++) begin
         tick(); v1 = 1'b1;
      end
      tick(); rst1 = 1'b1;
      tick(); rst1 = 1'b0;
      q1.push_back(mk("b_midrst", 1'b0, 1'b0, 1'b1, 16'hACE1));
      for (int j = 0; j < 5; j++) begin
         tick(); v1 = 1'b0;
         q1.push_back(mk("b_rerun", RTBL[j], 1'b0, 1'b1, LTBL[j]));
      end

      // Random, MAX_STALL=2, valid held for 200 cycles.
      tick(); rst2 = 1'b0; v2 = 1'b1;
      m2 = 16'hACE1; rq2 = 1'b0; cnt2 = 0;
      q2.push_back(mk("c_first", 1'b0, 1'b0));
      for (int i = 1; i < 200; i++) begin
         tick();
         nx   = 16'(lfsr_step(32'(m2), TAPS_DEF));
         f2   = (cnt2 == 1) && !rq2;
         ncnt = rq2 ? 0 : ((cnt2 < 2) ? cnt2 + 1 : cnt2);
         rq2  = nx[0] | f2;
         cnt2 = ncnt;
         m2   = nx;
         q2.push_back(mk("c_stall", rq2, rq2));
      end
      tick(); v2 = 1'b0;
      tick();
      tick();

      chk("c_max_run_le2", 32'(max_run2 <= 2), 32'd1);
      chk("c_cs_eq_ready", 32'(cs_cnt2), 32'(rdy_cnt2));
      chk("c_cs_seen", 32'(cs_cnt2 > 0), 32'd1);
      chk("q_drained", 32'(q0.size() + q1.size() + q2.size()), 32'd0);

      $display("End of test - %0d assertions evaluated, %0d failures",
               n_chk, n_fail);
      $finish;
   end

endmodule
